switch_input_conditioner: RTL and testbench



---
 rtl/switch_cond_pkg.sv | 13 +
 rtl/debounce_bit.sv | 47 ++++
 rtl/switch_input_conditioner.sv | 56 +++++
 tb/tb_switch_input_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_cond_pkg.sv
// Shared defaults and sizing helper for the switch input conditioner.
// The debounce counter width is derived from the required cycle count.
package switch_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000;
    localparam int SYNC_STAGES_DEFAULT     = 2;

    // Counter only has to reach cycles-1, so clog2 suffices; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: flop-chain synchroniser followed by a consecutive-mismatch
// debounce counter that flips the debounced level after DEBOUNCE_CYCLES cycles.
module debounce_bit
    import switch_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_in,
    output logic db,
    output logic settled
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_db;
    logic [CW-1:0]          r_cnt;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in};
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_db  <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign db      = r_db;
    assign settled = (w_s == r_db) && (r_cnt == '0);

endmodule

// File: rtl/switch_input_conditioner.sv
// Conditions raw slide switches into a clean byte for the priority encoder:
// per-bit sync + debounce, then a freezable output register with change strobe.
module switch_input_conditioner
    import switch_cond_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             hold,
    output logic [WIDTH-1:0] data,
    output logic             changed,
    output logic             stable
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_settled;
    logic [WIDTH-1:0] r_data;
    logic             r_changed;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_debounce (
                .clk     (clk),
                .rst_n   (rst_n),
                .sw_in   (sw_in[gi]),
                .db      (w_db[gi]),
                .settled (w_settled[gi])
            );
        end
    endgenerate

    // Strobe is registered with data so it coincides with the new value appearing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_changed <= !hold && (w_db != r_data);
            if (!hold) begin
                r_data <= w_db;
            end
        end
    end

    assign data    = r_data;
    assign changed = r_changed;
    assign stable  = &w_settled;

endmodule

// File: tb/tb_switch_input_conditioner.sv
// Randomised and directed bench for switch_input_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
// against a timestamp-based reference model of the debounce rules.
module tb_switch_input_conditioner;

    localparam int W = 8;
    localparam int D = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sw_in;
    logic         hold;
    logic [W-1:0] data;
    logic         changed;
    logic         stable;

    always #5 clk = ~clk;

    switch_input_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .SYNC_STAGES     (S)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_in   (sw_in),
        .hold    (hold),
        .data    (data),
        .changed (changed),
        .stable  (stable)
    );

    // Reference model: s is the switch value captured S-1 edges earlier; a bit flips
    // once it has disagreed with db on D consecutive edges since its last agreement/flip/reset.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_s, m_db, m_data;
    logic         m_changed, m_stable;
    int           last_ok[W];
    int           n_edge;
    int           n_checks;
    int           n_pass;

    task automatic tick(input logic r, input logic [W-1:0] s_v, input logic h);
        logic [W-1:0] db_before;
        rst_n = r;
        sw_in = s_v;
        hold  = h;
        @(posedge clk);
        n_edge++;
        if (!r) begin
            m_pipe.delete();
            for (int k = 0; k < S; k++) m_pipe.push_back('0);
            m_s       = '0;
            m_db      = '0;
            m_data    = '0;
            m_changed = 1'b0;
            for (int i = 0; i < W; i++) last_ok[i] = n_edge;
        end else begin
            db_before = m_db;
            for (int i = 0; i < W; i++) begin
                if (m_s[i] == m_db[i]) begin
                    last_ok[i] = n_edge;
                end else if (n_edge - last_ok[i] >= D) begin
                    m_db[i]    = m_s[i];
                    last_ok[i] = n_edge;
                end
            end
            m_changed = !h && (db_before != m_data);
            if (!h) m_data = db_before;
            m_pipe.push_front(s_v);
            void'(m_pipe.pop_back());
            m_s = m_pipe[S-1];
        end
        m_stable = 1'b1;
        for (int i = 0; i < W; i++)
            if (m_s[i] != m_db[i] || last_ok[i] != n_edge) m_stable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            tick(1'b1, '0, 1'b0);
            n_checks += 3;
            if (data !== 8'h00) $display("FAIL reset data got %h want 00", data); else n_pass++;
            if (changed !== 1'b0) $display("FAIL reset changed got %b want 0", changed); else n_pass++;
            if (stable !== 1'b1) $display("FAIL reset stable got %b want 1", stable); else n_pass++;
        end
    endtask

    task automatic test_clean_step();
        tick(1'b0, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        for (int j = 1; j <= 9; j++) begin
            tick(1'b1, 8'h80, 1'b0);
            n_checks += 3;
            if (data !== m_data) $display("FAIL step[%0d] data got %h want %h", j, data, m_data); else n_pass++;
            if (changed !== m_changed) $display("FAIL step[%0d] changed got %b want %b", j, changed, m_changed); else n_pass++;
            if (stable !== m_stable) $display("FAIL step[%0d] stable got %b want %b", j, stable, m_stable); else n_pass++;
            if (j == 6 || j == 7) begin
                n_checks++;
                if (data !== ((j == 7) ? 8'h80 : 8'h00))
                    $display("FAIL step_latency[%0d] data got %h", j, data);
                else n_pass++;
            end
            if (j == 2 || j == 5) begin
                n_checks++;
                if (stable !== 1'b0) $display("FAIL step_stable_low[%0d] got %b want 0", j, stable); else n_pass++;
            end
            if (j == 7 || j == 8) begin
                n_checks++;
                if (changed !== (j == 7)) $display("FAIL step_pulse[%0d] changed got %b want %b", j, changed, (j == 7)); else n_pass++;
            end
        end
    endtask

    task automatic test_bounce_reject();
        logic [W-1:0] pat;
        tick(1'b0, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        for (int j = 0; j < 18; j++) begin
            pat = (j < 12 && ((j / 3) % 2 == 0)) ? 8'h08 : 8'h00;
            tick(1'b1, pat, 1'b0);
            n_checks += 3;
            if (data !== 8'h00) $display("FAIL bounce[%0d] data got %h want 00", j, data); else n_pass++;
            if (changed !== 1'b0) $display("FAIL bounce[%0d] changed got %b want 0", j, changed); else n_pass++;
            if (stable !== m_stable) $display("FAIL bounce[%0d] stable got %b want %b", j, stable, m_stable); else n_pass++;
        end
    endtask

    task automatic test_bounce_settle();
        tick(1'b0, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        tick(1'b1, 8'h01, 1'b0);
        tick(1'b1, 8'h00, 1'b0);
        for (int j = 1; j <= 8; j++) begin
            tick(1'b1, 8'h01, 1'b0);
            n_checks += 2;
            if (data !== m_data) $display("FAIL settle[%0d] data got %h want %h", j, data, m_data); else n_pass++;
            if (changed !== m_changed) $display("FAIL settle[%0d] changed got %b want %b", j, changed, m_changed); else n_pass++;
            if (j == 6 || j == 7) begin
                n_checks++;
                if (data !== ((j == 7) ? 8'h01 : 8'h00)) $display("FAIL settle_latency[%0d] data got %h", j, data); else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        tick(1'b0, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            tick(1'b1, 8'h24, 1'b1);
            n_checks += 2;
            if (data !== 8'h00) $display("FAIL hold[%0d] data got %h want 00", j, data); else n_pass++;
            if (changed !== 1'b0) $display("FAIL hold[%0d] changed got %b want 0", j, changed); else n_pass++;
        end
        n_checks++;
        if (stable !== 1'b1) $display("FAIL hold_stable got %b want 1", stable); else n_pass++;
        tick(1'b1, 8'h24, 1'b0);
        n_checks += 2;
        if (data !== 8'h24) $display("FAIL hold_release data got %h want 24", data); else n_pass++;
        if (changed !== 1'b1) $display("FAIL hold_release changed got %b want 1", changed); else n_pass++;
        tick(1'b1, 8'h24, 1'b0);
        n_checks++;
        if (changed !== 1'b0) $display("FAIL hold_after changed got %b want 0", changed); else n_pass++;
    endtask

    task automatic test_reset_mid_count();
        tick(1'b0, '0, 1'b0);
        tick(1'b1, '0, 1'b0);
        for (int j = 0; j < 4; j++) tick(1'b1, 8'hFF, 1'b0);
        tick(1'b0, 8'hFF, 1'b0);
        n_checks++;
        if (data !== 8'h00) $display("FAIL midrst data got %h want 00", data); else n_pass++;
        for (int j = 1; j <= 7; j++) begin
            tick(1'b1, 8'hFF, 1'b0);
            n_checks += 2;
            if (data !== ((j == 7) ? 8'hFF : 8'h00)) $display("FAIL midrst[%0d] data got %h", j, data); else n_pass++;
            if (stable !== m_stable) $display("FAIL midrst[%0d] stable got %b want %b", j, stable, m_stable); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] sw_v;
        logic         h, r;
        sw_v = '0;
        tick(1'b0, '0, 1'b0);
        for (int j = 0; j < 500; j++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(5) == 0) sw_v[i] = ~sw_v[i];
            h = ($urandom_range(7) == 0);
            r = ($urandom_range(99) != 0);
            tick(r, sw_v, h);
            n_checks += 3;
            if (data !== m_data) $display("FAIL rand[%0d] data got %h want %h", j, data, m_data); else n_pass++;
            if (changed !== m_changed) $display("FAIL rand[%0d] changed got %b want %b", j, changed, m_changed); else n_pass++;
            if (stable !== m_stable) $display("FAIL rand[%0d] stable got %b want %b", j, stable, m_stable); else n_pass++;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        sw_in    = '0;
        hold     = 1'b0;
        n_edge   = 0;
        n_checks = 0;
        n_pass   = 0;
        @(negedge clk);
        test_reset();
        test_clean_step();
        test_bounce_reject();
        test_bounce_settle();
        test_hold();
        test_reset_mid_count();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
